// File: rtl/seq_multdiv_if.sv
// Operand/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface seq_multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/seq_multdiv.sv
// Multi-cycle signed multiply (radix-2 shift-add) and divide (restoring on
// magnitudes) with a one-cycle ready pulse. A start restarts from any state.
//
//   state | meaning
//   IDLE  | waiting for ctrl_MULT / ctrl_DIV
//   MUL   | WIDTH shift-add iterations, then one finishing cycle
//   DIV   | WIDTH restoring-division iterations, then one finishing cycle
//   DONE  | data_resultRDY high for this cycle, result/exception valid
module seq_multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clock,
    input  logic         reset,
    seq_multdiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo, dvs;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    logic               start, last;
    logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
    logic [2*WIDTH-1:0] addend;
    logic               mul_ovf;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   q_signed;
    logic               div_zero, div_ovf;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign last  = (cnt == CNT_W'(WIDTH));

    // 33-bit magnitudes so that |0x80000000| does not overflow
    assign a_ext = {bus.data_operandA[WIDTH-1], bus.data_operandA};
    assign b_ext = {bus.data_operandB[WIDTH-1], bus.data_operandB};
    assign a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_mag = b_ext[WIDTH] ? -b_ext : b_ext;

    // The sign bit of a two's-complement multiplier carries weight -2^(WIDTH-1)
    always_comb begin
        addend = '0;
        if (mplier[0])
            addend = (cnt == CNT_W'(WIDTH-1)) ? -mcand : mcand;
    end

    assign mul_ovf = ~((&acc[2*WIDTH-1:WIDTH-1]) | ~(|acc[2*WIDTH-1:WIDTH-1]));

    assign shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs};
    assign q_signed = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) ? -quo : quo;
    assign div_zero = (b_reg == '0);
    assign div_ovf  = (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_reg);

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = bus.ctrl_MULT ? MUL : DIV;
        end else begin
            case (state)
                MUL, DIV: if (last) state_nx = DONE;
                DONE:     state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.data_resultRDY = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            a_reg  <= bus.data_operandA;
            b_reg  <= bus.data_operandB;
            acc    <= '0;
            mcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
            mplier <= bus.data_operandB;
            rem    <= '0;
            quo    <= a_mag[WIDTH-1:0];
            dvs    <= b_mag[WIDTH-1:0];
        end else begin
            case (state)
                MUL: begin
                    if (!last) begin
                        acc    <= acc + addend;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end else begin
                        result_q <= acc[WIDTH-1:0];
                        exc_q    <= mul_ovf;
                    end
                end
                DIV: begin
                    if (!last) begin
                        if (!diff[WIDTH+1]) begin
                            rem <= diff[WIDTH:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted;
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_W'(1);
                    end else if (div_zero) begin
                        result_q <= '0;
                        exc_q    <= 1'b1;
                    end else begin
                        result_q <= q_signed;
                        exc_q    <= div_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;

endmodule

// File: tb/tb_seq_multdiv.sv
// Directed bench for seq_multdiv: arithmetic reference model compared every
// cycle, plus literal expectations and latency checks per operation.
module tb_seq_multdiv;

    logic clock = 1'b0;
    logic reset = 1'b1;

    seq_multdiv_if #(.WIDTH(32)) bus();

    seq_multdiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result: {exception, result}
    function automatic logic [32:0] model_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q;
        if (mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p != longint'($signed(p[31:0]))), p[31:0]};
        end
        if (b == 32'd0)
            return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q[31:0]};
    endfunction

    int          pend = 0;
    logic [31:0] pend_res, m_res;
    logic        pend_exc, m_exc, m_rdy;

    always @(posedge clock) begin
        if (reset) begin
            pend  <= 0;
            m_rdy <= 1'b0;
            m_res <= '0;
            m_exc <= 1'b0;
        end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            pend                 <= 33;
            {pend_exc, pend_res} <= model_op(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB);
            m_rdy                <= 1'b0;
        end else if (pend == 1) begin
            pend  <= 0;
            m_rdy <= 1'b1;
            m_res <= pend_res;
            m_exc <= pend_exc;
        end else begin
            if (pend != 0) pend <= pend - 1;
            m_rdy <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cmp_rdy", {31'd0, bus.data_resultRDY}, {31'd0, m_rdy});
            check("cmp_result", bus.data_result, m_res);
            check("cmp_exc", {31'd0, bus.data_exception}, {31'd0, m_exc});
        end
    end

    // Drive a start at the current negedge; returns at the negedge after the start edge.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_rdy(input string name, input logic [31:0] er, input logic ee);
        int k = 0;
        while (!bus.data_resultRDY && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({name, "_latency"}, k, 33);
        check({name, "_result"}, bus.data_result, er);
        check({name, "_exc"}, {31'd0, bus.data_exception}, {31'd0, ee});
        @(negedge clock);
        check({name, "_rdy_drop"}, {31'd0, bus.data_resultRDY}, 32'd0);
        check({name, "_hold"}, bus.data_result, er);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cmp_en = 1'b1;
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exc", {31'd0, bus.data_exception}, 32'd0);
        check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);

        issue(1, 0, 32'd7, 32'hFFFF_FFFD);
        wait_rdy("mul_7x-3", 32'hFFFF_FFEB, 1'b0);
        issue(1, 0, 32'h0001_0000, 32'h0001_0000);
        wait_rdy("mul_ovf", 32'h0000_0000, 1'b1);
        issue(1, 0, 32'h7FFF_FFFF, 32'd1);
        wait_rdy("mul_max", 32'h7FFF_FFFF, 1'b0);
        issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy("mul_min_neg1", 32'h8000_0000, 1'b1);

        issue(0, 1, 32'hFFFF_FFF9, 32'd2);
        wait_rdy("div_-7/2", 32'hFFFF_FFFD, 1'b0);
        issue(0, 1, 32'd100, 32'hFFFF_FFF6);
        wait_rdy("div_100/-10", 32'hFFFF_FFF6, 1'b0);
        issue(0, 1, 32'd5, 32'd0);
        wait_rdy("div_zero", 32'd0, 1'b1);
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy("div_ovf", 32'h8000_0000, 1'b1);
        issue(0, 1, 32'h8000_0000, 32'd7);
        wait_rdy("div_min/7", 32'hEDB6_DB6E, 1'b0);

        issue(1, 0, 32'd3, 32'd4);
        repeat (9) @(negedge clock);
        issue(0, 1, 32'd20, 32'd5);
        wait_rdy("restart", 32'd4, 1'b0);

        issue(1, 0, 32'd6, 32'd7);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_result", bus.data_result, 32'd0);
        check("midreset_exc", {31'd0, bus.data_exception}, 32'd0);
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY) rdy_seen++;
        end
        check("midreset_no_rdy", rdy_seen, 0);

        issue(1, 1, 32'd6, 32'd3);
        wait_rdy("mul_wins", 32'd18, 1'b0);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
